// File: rtl/romulusn_ctrl_pkg.sv
// Shared definitions for the Romulus-N block controller.
//   state_t          : controller phase encoding
//   ROUNDS_PER_CYC   : SKINNY rounds unrolled per RND cycle
//   RND_CYCLES       : RND cycles per block (RND_CYCLES * ROUNDS_PER_CYC = 40 rounds)
//   BEATS            : 32-bit beats per 128-bit transfer
//   RC_WIDTH         : round-constant LFSR width
//   rc_step()        : one step of the 6-bit round-constant LFSR
package romulusn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEY  = 3'd1,
    ST_DATA = 3'd2,
    ST_RND  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  localparam int ROUNDS_PER_CYC = 8;
  localparam int RND_CYCLES     = 5;
  localparam int BEATS          = 4;
  localparam int RC_WIDTH       = 6;

  // Shift left, feed back rc[5] ^ rc[4] ^ 1.
  function automatic logic [RC_WIDTH-1:0] rc_step(input logic [RC_WIDTH-1:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/romulusn_rc8.sv
// Combinational unroll of the round-constant LFSR.
//   rc_in  : current LFSR register value
//   rc_out : rc_out[i] is the value i+1 steps after rc_in (i = 0..ROUNDS_PER_CYC-1)
module romulusn_rc8
  import romulusn_ctrl_pkg::*;
(
  input  logic [RC_WIDTH-1:0]                     rc_in,
  output logic [ROUNDS_PER_CYC-1:0][RC_WIDTH-1:0] rc_out
);

  logic [RC_WIDTH-1:0] chain [ROUNDS_PER_CYC+1];

  assign chain[0] = rc_in;

  for (genvar gi = 0; gi < ROUNDS_PER_CYC; gi++) begin : g_step
    assign chain[gi+1] = rc_step(chain[gi]);
    assign rc_out[gi]  = chain[gi+1];
  end

endmodule

// File: rtl/romulusn_ctrl.sv
// Romulus-N block controller: sequences key load (4 sdi beats), data load
// (4 pdi beats), 5 unrolled-round cycles (8 SKINNY-128-384+ rounds each) and
// output (4 pdo beats), driving datapath enables and round constants.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   start                    : begin a block (accepted in IDLE only)
//   dec_in, cnt_inc, ad_blk  : block mode, counter advance, AD select (sampled on start)
//   dom_in / domain          : domain byte sampled on start / held copy
//   key_valid / key_ready    : sdi beat handshake
//   pdi_valid / pdi_ready    : pdi beat handshake
//   pdo_valid / pdo_ready    : pdo beat handshake
//   s/x/y/z rst,enc,se, erst : datapath register controls
//   correct_cnt, tk1s        : counter-advance select, TK1 source select
//   decrypt                  : decrypt mask during OUT
//   constant..constant8      : round constants for unrolled rounds 0..7
//   done                     : one-cycle pulse after the last pdo beat
//
// Build option: define ROMULUSN_CTRL_DECRYPT_EN to drive decrypt from the
// sampled dec_in during OUT; otherwise decrypt is tied to zero.
//
// Beat-qualified enables (xse, sse, ...) are formed from a registered
// ready/valid flag ANDed with the partner's valid/ready so they are high only
// in the cycle the beat actually transfers. Everything else is registered.
module romulusn_ctrl
  import romulusn_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dec_in,
  input  logic       cnt_inc,
  input  logic       ad_blk,
  input  logic [7:0] dom_in,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       pdi_valid,
  output logic       pdi_ready,
  output logic       pdo_valid,
  input  logic       pdo_ready,
  output logic       srst,
  output logic       senc,
  output logic       sse,
  output logic       xrst,
  output logic       xenc,
  output logic       xse,
  output logic       yrst,
  output logic       yenc,
  output logic       yse,
  output logic       zrst,
  output logic       zenc,
  output logic       zse,
  output logic       erst,
  output logic       correct_cnt,
  output logic       tk1s,
  output logic [7:0] domain,
  output logic [3:0] decrypt,
  output logic [5:0] constant,
  output logic [5:0] constant2,
  output logic [5:0] constant3,
  output logic [5:0] constant4,
  output logic [5:0] constant5,
  output logic [5:0] constant6,
  output logic [5:0] constant7,
  output logic [5:0] constant8,
  output logic       done
);

  state_t              state_reg;
  logic [1:0]          beat_reg;
  logic [2:0]          rnd_cnt_reg;
  logic [RC_WIDTH-1:0] rc_reg;
  logic [7:0]          dom_reg;
  logic                cnt_inc_reg;
  logic                tk1s_reg;
  logic                key_ready_reg;
  logic                pdi_ready_reg;
  logic                pdo_valid_reg;
  logic                rnd_en_reg;
  logic                rst_pulse_reg;
  logic                erst_reg;
  logic                cnt_pulse_reg;
  logic                done_reg;

  logic key_xfer, pdi_xfer, pdo_xfer;
  logic [ROUNDS_PER_CYC-1:0][RC_WIDTH-1:0] rc_vals;

  assign key_xfer = key_ready_reg & key_valid;
  assign pdi_xfer = pdi_ready_reg & pdi_valid;
  assign pdo_xfer = pdo_valid_reg & pdo_ready;

  romulusn_rc8 u_rc8 (
    .rc_in  (rc_reg),
    .rc_out (rc_vals)
  );

`ifdef ROMULUSN_CTRL_DECRYPT_EN
  logic       dec_reg;
  logic [3:0] decrypt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_reg     <= 1'b0;
      decrypt_reg <= 4'h0;
    end else begin
      if (state_reg == ST_IDLE && start)
        dec_reg <= dec_in;
      // Mirror pdo_valid: set entering OUT, cleared leaving it.
      if (state_reg == ST_RND && rnd_cnt_reg == 3'(RND_CYCLES-1))
        decrypt_reg <= {4{dec_reg}};
      else if (state_reg == ST_OUT && pdo_xfer && beat_reg == 2'(BEATS-1))
        decrypt_reg <= 4'h0;
    end
  end

  assign decrypt = decrypt_reg;
`else
  logic dec_in_unused;
  assign dec_in_unused = dec_in;
  assign decrypt       = 4'h0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      beat_reg      <= 2'd0;
      rnd_cnt_reg   <= 3'd0;
      rc_reg        <= '0;
      dom_reg       <= 8'h00;
      cnt_inc_reg   <= 1'b0;
      tk1s_reg      <= 1'b0;
      key_ready_reg <= 1'b0;
      pdi_ready_reg <= 1'b0;
      pdo_valid_reg <= 1'b0;
      rnd_en_reg    <= 1'b0;
      rst_pulse_reg <= 1'b0;
      erst_reg      <= 1'b0;
      cnt_pulse_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      rst_pulse_reg <= 1'b0;
      erst_reg      <= 1'b0;
      cnt_pulse_reg <= 1'b0;
      done_reg      <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg     <= ST_KEY;
            beat_reg      <= 2'd0;
            dom_reg       <= dom_in;
            cnt_inc_reg   <= cnt_inc;
            tk1s_reg      <= ad_blk;
            key_ready_reg <= 1'b1;
            rst_pulse_reg <= 1'b1;
          end
        end

        ST_KEY: begin
          if (key_xfer) begin
            beat_reg <= beat_reg + 2'd1;
            if (beat_reg == 2'(BEATS-1)) begin
              state_reg     <= ST_DATA;
              key_ready_reg <= 1'b0;
              pdi_ready_reg <= 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (pdi_xfer) begin
            beat_reg <= beat_reg + 2'd1;
            if (beat_reg == 2'(BEATS-1)) begin
              state_reg     <= ST_RND;
              pdi_ready_reg <= 1'b0;
              rnd_en_reg    <= 1'b1;
              rnd_cnt_reg   <= 3'd0;
              rc_reg        <= '0;
            end
          end
        end

        ST_RND: begin
          // Jump the LFSR past the eight constants consumed this cycle.
          rc_reg      <= rc_vals[ROUNDS_PER_CYC-1];
          rnd_cnt_reg <= rnd_cnt_reg + 3'd1;
          if (rnd_cnt_reg == 3'(RND_CYCLES-1)) begin
            state_reg     <= ST_OUT;
            rnd_en_reg    <= 1'b0;
            pdo_valid_reg <= 1'b1;
            erst_reg      <= 1'b1;
          end
        end

        ST_OUT: begin
          if (pdo_xfer) begin
            beat_reg <= beat_reg + 2'd1;
            if (beat_reg == 2'(BEATS-1)) begin
              state_reg     <= ST_IDLE;
              pdo_valid_reg <= 1'b0;
              tk1s_reg      <= 1'b0;
              done_reg      <= 1'b1;
              cnt_pulse_reg <= cnt_inc_reg;
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign key_ready   = key_ready_reg;
  assign pdi_ready   = pdi_ready_reg;
  assign pdo_valid   = pdo_valid_reg;

  assign srst        = rst_pulse_reg;
  assign xrst        = rst_pulse_reg;
  assign yrst        = rst_pulse_reg;
  assign zrst        = rst_pulse_reg;
  assign erst        = erst_reg;

  assign senc        = rnd_en_reg | pdi_xfer | pdo_xfer;
  assign sse         = pdi_xfer | pdo_xfer;
  assign xenc        = rnd_en_reg | key_xfer;
  assign xse         = key_xfer;
  assign yenc        = rnd_en_reg | pdi_xfer;
  assign yse         = pdi_xfer;
  // The counter advance lands in the IDLE cycle after OUT, never overlapping RND.
  assign zenc        = rnd_en_reg | cnt_pulse_reg;
  assign zse         = cnt_pulse_reg;
  assign correct_cnt = cnt_pulse_reg;

  assign tk1s        = tk1s_reg;
  assign domain      = dom_reg;
  assign done        = done_reg;

  // Constants are only meaningful while rounds run; hold them at zero otherwise.
  assign constant    = rnd_en_reg ? rc_vals[0] : '0;
  assign constant2   = rnd_en_reg ? rc_vals[1] : '0;
  assign constant3   = rnd_en_reg ? rc_vals[2] : '0;
  assign constant4   = rnd_en_reg ? rc_vals[3] : '0;
  assign constant5   = rnd_en_reg ? rc_vals[4] : '0;
  assign constant6   = rnd_en_reg ? rc_vals[5] : '0;
  assign constant7   = rnd_en_reg ? rc_vals[6] : '0;
  assign constant8   = rnd_en_reg ? rc_vals[7] : '0;

endmodule

// File: tb/tb_romulusn_ctrl.sv
// Self-checking bench for romulusn_ctrl. Each block is driven from a plan of
// stall cycles per beat; the expected outputs for every cycle come from the
// phase the block must be in (from beat counts) and the LFSR sequence.
module tb_romulusn_ctrl;

`ifdef ROMULUSN_CTRL_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  // Bit positions inside the packed observation vector.
  localparam int B_PDI_READY = 77;
  localparam int B_SSE       = 73;
  localparam int B_ZENC      = 65;
  localparam int B_ZSE       = 64;
  localparam int B_CCNT      = 62;

  typedef logic [78:0] vec_t;

  logic clk, rst, start, dec_in, cnt_inc, ad_blk;
  logic [7:0] dom_in;
  logic key_valid, key_ready, pdi_valid, pdi_ready, pdo_valid, pdo_ready;
  logic srst, senc, sse, xrst, xenc, xse, yrst, yenc, yse, zrst, zenc, zse;
  logic erst, correct_cnt, tk1s, done;
  logic [7:0] domain;
  logic [3:0] decrypt;
  logic [5:0] constant, constant2, constant3, constant4;
  logic [5:0] constant5, constant6, constant7, constant8;

  int checks;
  int passed;
  logic [5:0] lfsr_seq [0:40];
  logic [7:0] held_dom;
  bit   blk_cnt, blk_ad, blk_dec;
  int   stall_plan [12];
  vec_t obs_q [$];
  vec_t exp_q [$];
  int   ph_q  [$];

  romulusn_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dec_in(dec_in), .cnt_inc(cnt_inc),
    .ad_blk(ad_blk), .dom_in(dom_in), .key_valid(key_valid), .key_ready(key_ready),
    .pdi_valid(pdi_valid), .pdi_ready(pdi_ready), .pdo_valid(pdo_valid),
    .pdo_ready(pdo_ready), .srst(srst), .senc(senc), .sse(sse), .xrst(xrst),
    .xenc(xenc), .xse(xse), .yrst(yrst), .yenc(yenc), .yse(yse), .zrst(zrst),
    .zenc(zenc), .zse(zse), .erst(erst), .correct_cnt(correct_cnt), .tk1s(tk1s),
    .domain(domain), .decrypt(decrypt), .constant(constant), .constant2(constant2),
    .constant3(constant3), .constant4(constant4), .constant5(constant5),
    .constant6(constant6), .constant7(constant7), .constant8(constant8), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t pack_obs();
    return {key_ready, pdi_ready, pdo_valid, srst, senc, sse, xrst, xenc, xse,
            yrst, yenc, yse, zrst, zenc, zse, erst, correct_cnt, tk1s, done,
            domain, decrypt, constant, constant2, constant3, constant4,
            constant5, constant6, constant7, constant8};
  endfunction

  // Expected outputs for one cycle. p: 0 idle, 1 key, 2 data, 3 rounds,
  // 4 out, 5 the idle cycle right after the last output beat.
  function automatic vec_t model(int p, bit xfer, bit first, int j, bit cnt,
                                 bit ad, bit dec, logic [7:0] dom);
    bit rnd, kx, dx, ox, cp, r4;
    logic [3:0]  dcr;
    logic [47:0] cs;
    rnd = (p == 3);
    kx  = xfer && (p == 1);
    dx  = xfer && (p == 2);
    ox  = xfer && (p == 4);
    cp  = (p == 5) && cnt;
    r4  = (p == 1) && first;
    dcr = 4'h0;
    if (DEC_EN && p == 4 && dec) dcr = 4'hF;
    cs = '0;
    if (rnd)
      for (int k = 0; k < 8; k++) cs[47-6*k -: 6] = lfsr_seq[8*j + k + 1];
    return {p == 1, p == 2, p == 4, r4, rnd | dx | ox, dx | ox, r4, rnd | kx, kx,
            r4, rnd | dx, dx, r4, rnd | cp, cp, (p == 4) && first, cp,
            ad && (p >= 1) && (p <= 4), p == 5, dom, dcr, cs};
  endfunction

  task automatic record(input int p, input bit xfer, input bit first, input int j);
    obs_q.push_back(pack_obs());
    exp_q.push_back(model(p, xfer, first, j, blk_cnt, blk_ad, blk_dec, held_dom));
    ph_q.push_back(p);
  endtask

  task automatic noise(input bit busy);
    start     = busy ? 1'($urandom) : 1'b0;
    cnt_inc   = 1'($urandom);
    ad_blk    = 1'($urandom);
    dec_in    = 1'($urandom);
    dom_in    = 8'($urandom);
    key_valid = 1'($urandom);
    pdi_valid = 1'($urandom);
    pdo_ready = 1'($urandom);
  endtask

  // Drive one whole block following stall_plan and record a trace.
  task automatic drive_block(input bit cnt, input bit ad, input bit dec,
                             input logic [7:0] dom, input bit busy);
    bit first;
    int p;
    obs_q.delete(); exp_q.delete(); ph_q.delete();
    blk_cnt = cnt; blk_ad = ad; blk_dec = dec;
    @(negedge clk);
    start = 1'b1; cnt_inc = cnt; ad_blk = ad; dec_in = dec; dom_in = dom;
    key_valid = 1'b0; pdi_valid = 1'b0; pdo_ready = 1'b0;
    #1 record(0, 1'b0, 1'b0, 0);
    held_dom = dom;
    for (int b = 0; b < 12; b++) begin
      p = (b < 4) ? 1 : ((b < 8) ? 2 : 4);
      first = (b == 0) || (b == 8);
      if (b == 8) begin
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          noise(busy);
          #1 record(3, 1'b0, 1'b0, j);
        end
      end
      for (int s = 0; s <= stall_plan[b]; s++) begin
        bit xfer;
        xfer = (s == stall_plan[b]);
        @(negedge clk);
        noise(busy);
        if (p == 1) key_valid = xfer;
        if (p == 2) pdi_valid = xfer;
        if (p == 4) pdo_ready = xfer;
        #1 record(p, xfer, first, 0);
        first = 1'b0;
      end
    end
    @(negedge clk);
    noise(1'b0);
    #1 record(5, 1'b0, 1'b0, 0);
    @(negedge clk);
    noise(1'b0);
    #1 record(0, 1'b0, 1'b0, 0);
  endtask

  task automatic clear_plan();
    for (int b = 0; b < 12; b++) stall_plan[b] = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; dec_in = 1'b1; cnt_inc = 1'b1; ad_blk = 1'b1;
    dom_in = 8'($urandom); key_valid = 1'b1; pdi_valid = 1'b1; pdo_ready = 1'b1;
    held_dom = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (pack_obs() !== '0) $display("FAIL reset_outputs: got %h want 0", pack_obs());
      else passed++;
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b0; key_valid = 1'b0; pdi_valid = 1'b0; pdo_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (pack_obs() !== model(0, 0, 0, 0, 0, 0, 0, 8'h00))
      $display("FAIL reset_release_idle: got %h want %h", pack_obs(), model(0, 0, 0, 0, 0, 0, 0, 8'h00));
    else passed++;
  endtask

  task automatic test_latency();
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    @(negedge clk);
    dom_in = 8'($urandom); held_dom = dom_in; cnt_inc = 1'b0; ad_blk = 1'b0; dec_in = 1'b0;
    key_valid = 1'b1; pdi_valid = 1'b1; pdo_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); n++; #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 17) $display("FAIL done_latency: got %0d cycles (seen=%0d) want 17", n, seen);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) $display("FAIL done_width: got %b want 0", done);
    else passed++;
    key_valid = 1'b0; pdi_valid = 1'b0; pdo_ready = 1'b0;
  endtask

  task automatic test_constants();
    logic [5:0] rc_tab [8];
    logic [5:0] got;
    int idx;
    rc_tab = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B};
    clear_plan();
    drive_block(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b0);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL trace_nostall cyc=%0d phase=%0d got=%h want=%h", i, ph_q[i], obs_q[i], exp_q[i]);
      else passed++;
    end
    idx = 0;
    for (int i = ph_q.size() - 1; i >= 0; i--) if (ph_q[i] == 3) idx = i;
    for (int k = 0; k < 8; k++) begin
      got = obs_q[idx][47-6*k -: 6];
      checks++;
      if (got !== rc_tab[k]) $display("FAIL rnd0_constant%0d: got %h want %h", k + 1, got, rc_tab[k]);
      else passed++;
    end
    checks++;
    if (obs_q[idx+1][47:42] !== 6'h37 || obs_q[idx+1][41:36] !== 6'h2F)
      $display("FAIL rnd1_constants: got %h,%h want 37,2f", obs_q[idx+1][47:42], obs_q[idx+1][41:36]);
    else passed++;
  endtask

  task automatic test_stall();
    int rdy, sse_n;
    rdy = 0; sse_n = 0;
    clear_plan();
    stall_plan[6] = 3;
    drive_block(1'b0, 1'b1, 1'b0, 8'($urandom), 1'b0);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL trace_stall cyc=%0d phase=%0d got=%h want=%h", i, ph_q[i], obs_q[i], exp_q[i]);
      else passed++;
      if (obs_q[i][B_PDI_READY]) begin
        rdy++;
        if (obs_q[i][B_SSE]) sse_n++;
      end
    end
    checks++;
    if (rdy != 7 || sse_n != 4) $display("FAIL stall_data_cycles: got %0d/%0d want 7/4", rdy, sse_n);
    else passed++;
  endtask

  task automatic test_counter();
    int pulses, bad_dom;
    for (int t = 0; t < 2; t++) begin
      pulses = 0; bad_dom = 0;
      clear_plan();
      for (int b = 0; b < 12; b++) stall_plan[b] = $urandom_range(0, 2);
      drive_block(t == 0, 1'b0, 1'b0, 8'h04, 1'b0);
      foreach (obs_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i])
          $display("FAIL trace_counter cyc=%0d phase=%0d got=%h want=%h", i, ph_q[i], obs_q[i], exp_q[i]);
        else passed++;
        if (ph_q[i] == 5 && obs_q[i][B_ZENC] && obs_q[i][B_ZSE] && obs_q[i][B_CCNT]) pulses++;
        if (ph_q[i] >= 1 && obs_q[i][59:52] !== 8'h04) bad_dom++;
      end
      checks++;
      if (pulses != ((t == 0) ? 1 : 0) || bad_dom != 0)
        $display("FAIL counter_pulse cnt_inc=%0d: got pulses=%0d bad_dom=%0d want %0d/0", t == 0, pulses, bad_dom, (t == 0) ? 1 : 0);
      else passed++;
    end
  endtask

  task automatic test_decrypt();
    int out_n, dec_f, dec_out_bad;
    out_n = 0; dec_f = 0; dec_out_bad = 0;
    clear_plan();
    for (int b = 8; b < 12; b++) stall_plan[b] = $urandom_range(0, 2);
    drive_block(1'b0, 1'b1, 1'b1, 8'($urandom), 1'b0);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL trace_decrypt cyc=%0d phase=%0d got=%h want=%h", i, ph_q[i], obs_q[i], exp_q[i]);
      else passed++;
      if (ph_q[i] == 4) begin
        out_n++;
        if (obs_q[i][51:48] === 4'hF) dec_f++;
      end else if (obs_q[i][51:48] !== 4'h0) dec_out_bad++;
    end
    checks++;
    if (dec_f != (DEC_EN ? out_n : 0) || dec_out_bad != 0)
      $display("FAIL decrypt_window: got %0d F-cycles, %0d stray want %0d, 0", dec_f, dec_out_bad, DEC_EN ? out_n : 0);
    else passed++;
  endtask

  task automatic test_busy_start();
    clear_plan();
    for (int b = 0; b < 12; b++) stall_plan[b] = $urandom_range(0, 2);
    drive_block(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'b1);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL trace_busy_start cyc=%0d phase=%0d got=%h want=%h", i, ph_q[i], obs_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_rnd();
    int bad;
    vec_t idle_exp;
    bad = 0;
    @(negedge clk);
    start = 1'b1; dom_in = 8'hA5; cnt_inc = 1'b1; ad_blk = 1'b1; dec_in = 1'b1;
    key_valid = 1'b1; pdi_valid = 1'b1; pdo_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    checks++;
    if (senc !== 1'b1 || constant !== 6'h37)
      $display("FAIL mid_rnd_reached: got senc=%b constant=%h want 1,37", senc, constant);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (pack_obs() !== '0) $display("FAIL reset_mid_rnd_async: got %h want 0", pack_obs());
    else passed++;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (pack_obs() !== '0) $display("FAIL reset_mid_rnd_held: got %h want 0", pack_obs());
    else passed++;
    rst = 1'b1;
    held_dom = 8'h00;
    idle_exp = model(0, 0, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk); #1;
      if (pack_obs() !== idle_exp) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL reset_mid_rnd_idle: got %0d non-idle cycles want 0", bad);
    else passed++;
    key_valid = 1'b0; pdi_valid = 1'b0; pdo_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      for (int b = 0; b < 12; b++) stall_plan[b] = $urandom_range(0, 3);
      drive_block(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      foreach (obs_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i])
          $display("FAIL trace_random blk=%0d cyc=%0d phase=%0d got=%h want=%h", n, i, ph_q[i], obs_q[i], exp_q[i]);
        else passed++;
      end
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    held_dom = 8'h00;
    lfsr_seq[0] = 6'h00;
    for (int n = 0; n < 40; n++)
      lfsr_seq[n+1] = {lfsr_seq[n][4:0], ~(lfsr_seq[n][5] ^ lfsr_seq[n][4])};
    test_reset();
    test_latency();
    test_constants();
    test_stall();
    test_counter();
    test_decrypt();
    test_busy_start();
    test_reset_mid_rnd();
    test_constants();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/romulusn_ctrl.md
ROMULUSN_CTRL -- requirements
Module: romulusn_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  one-cycle pulse in IDLE: begin one block; ignored elsewhere.
REQ-004 dec_in, cnt_inc, ad_blk  in  1 each  block mode, counter-advance request and AD/message select, sampled on start.
REQ-005 dom_in  in  8  domain byte, sampled on start, held on domain.
REQ-006 key_valid/key_ready, pdi_valid/pdi_ready  in/out  1 each  32-bit sdi/pdi beat handshakes; a beat transfers when valid&ready.
REQ-007 pdo_valid out, pdo_ready in  1 each  32-bit output beat handshake.
REQ-008 srst,senc,sse, xrst,xenc,xse, yrst,yenc,yse, zrst,zenc,zse, erst, correct_cnt, tk1s  out  1 each  datapath controls.
REQ-009 domain out 8; decrypt out 4; constant..constant8 out 6 each (round constants for unrolled rounds 0..7).
REQ-010 done  out  1  one-cycle pulse when last pdo beat transfers.

Function
REQ-011 States: IDLE, KEY (4 sdi beats), DATA (4 pdi beats), RND (5 cycles), OUT (4 pdo beats), then IDLE.
REQ-012 IDLE->KEY on start; KEY->DATA after beat 3; DATA->RND after beat 3; RND->OUT after cycle 4; OUT->IDLE after beat 3.
REQ-013 2-bit beat counter counts transfers only; stalls (valid=0 or ready=0) hold state and all enables low.
REQ-014 KEY: key_ready=1; xse=xenc=1 exactly on transferring cycles.
REQ-015 DATA: pdi_ready=1; sse=senc=1 and yse=yenc=1 on transferring cycles.
REQ-016 RND: senc=xenc=yenc=zenc=1, sse=xse=yse=zse=0 each cycle; 5 cycles x 8 rounds = 40 SKINNY-128-384+ rounds.
REQ-017 Round constant: 6-bit LFSR rc, next = {rc[4:0], rc[5]^rc[4]^1}; constant..constant8 are the 8 successive values following the current register; register advances by 8 per RND cycle; cleared to 0 on entering RND.
REQ-018 OUT: pdo_valid=1; sse=senc=1 on transferring cycles; decrypt driven as in REQ-024.
REQ-019 Counter: on last OUT beat, if cnt_inc sampled 1, pulse zenc with correct_cnt=1 and zse=1 for one cycle (advance LFSR counter); tk1s = ad_blk throughout block.
REQ-020 srst,xrst,yrst,zrst pulse one cycle on start; erst pulses one cycle when entering OUT.
REQ-021 start while busy is ignored; no queued request.
REQ-022 pdo_valid and pdi_ready/key_ready never asserted outside their states.

Reset
REQ-023 rst low: state IDLE, beat counter 0, rc 0, sampled mode/domain 0, every output 0, asynchronously; release synchronous to clk; reset mid-block abandons it with no done.

Configuration
REQ-024 ROMULUSN_CTRL_DECRYPT_EN defined: decrypt = {4{dec_in}} during OUT, else 0. Undefined: decrypt tied 4'h0, dec_in unused.

Structure
REQ-025 Shared package holds state encoding, ROUNDS_PER_CYC=8, RND_CYCLES=5, BEATS=4, RC_WIDTH=6.
REQ-026 One sub-module romulusn_rc8: combinational 8-step rc LFSR unroll; controller instantiates it once.

Verification
REQ-027 Reset mid-RND -> all outputs 0 immediately, IDLE after release, no done.
REQ-028 start, no stalls -> KEY 4, DATA 4, RND 5, OUT 4 cycles; done 17 cycles after start sampled.
REQ-029 First RND cycle -> constants 01,03,07,0F,1F,3E,3D,3B; second cycle constant=37, constant2=2F.
REQ-030 pdi_valid low 3 cycles mid-DATA -> sse/senc/yse low those cycles, beat count unchanged, ordering intact.
REQ-031 cnt_inc=1, dom_in=8'h04 -> domain=04 all block, one zenc+correct_cnt pulse on last OUT beat; cnt_inc=0 -> none.
REQ-032 Macro defined, dec_in=1 -> decrypt=4'hF during OUT only; undefined -> decrypt always 0.
